// File: rtl/float_sort_pkg.sv
// Shared FP64 constants, triplet collector states and the ordered compare used by the sorter.
package float_sort_pkg;

    localparam int FLEN     = 64;
    localparam int EXP_W    = 11;
    localparam int MAN_W    = 52;
    localparam int TRIPLE_N = 3;

    typedef enum logic [1:0] {
        FILL0,
        FILL1,
        FILL2,
        FULL
    } triplet_state_t;

    function automatic logic is_nan(input logic [FLEN-1:0] x);
        logic expAllOnes;
        logic manNonZero;
        expAllOnes = (x[FLEN-2 -: EXP_W] == {EXP_W{1'b1}});
        manNonZero = (x[MAN_W-1:0] != {MAN_W{1'b0}});
        return expAllOnes & manNonZero;
    endfunction

    // Sign-magnitude ordering; +0 and -0 compare equal. Meaningless for NaN operands,
    // which the caller flags separately.
    function automatic logic f_less_or_equal(input logic [FLEN-1:0] a,
                                             input logic [FLEN-1:0] b);
        logic            aNeg;
        logic            bNeg;
        logic [FLEN-2:0] aMag;
        logic [FLEN-2:0] bMag;
        logic            result;
        aNeg = a[FLEN-1];
        bNeg = b[FLEN-1];
        aMag = a[FLEN-2:0];
        bMag = b[FLEN-2:0];
        if ((aMag == '0) && (bMag == '0)) begin
            result = 1'b1;
        end else if (aNeg != bNeg) begin
            result = aNeg;
        end else if (!aNeg) begin
            result = (aMag <= bMag);
        end else begin
            result = (aMag >= bMag);
        end
        return result;
    endfunction

endpackage

// File: rtl/sort_three_floats.sv
// Combinational three-input FP sorter built from three pairwise ordered compares.
module sort_three_floats
    import float_sort_pkg::*;
(
    input  logic [TRIPLE_N-1:0][FLEN-1:0] slots_i,
    output logic [0:TRIPLE_N-1][FLEN-1:0] sorted_o,
    output logic                          err_o
);

    logic [FLEN-1:0] a;
    logic [FLEN-1:0] b;
    logic [FLEN-1:0] c;
    logic            le01;
    logic            le02;
    logic            le12;

    assign a = slots_i[0];
    assign b = slots_i[1];
    assign c = slots_i[2];

    assign le01  = f_less_or_equal(a, b);
    assign le02  = f_less_or_equal(a, c);
    assign le12  = f_less_or_equal(b, c);
    assign err_o = is_nan(a) | is_nan(b) | is_nan(c);

    // The three compare results select one of the six permutations.
    always_comb begin
        sorted_o[0] = a;
        sorted_o[1] = b;
        sorted_o[2] = c;
        if (le01 && le12) begin
            sorted_o[0] = a;
            sorted_o[1] = b;
            sorted_o[2] = c;
        end else if (le01 && le02) begin
            sorted_o[0] = a;
            sorted_o[1] = c;
            sorted_o[2] = b;
        end else if (le01) begin
            sorted_o[0] = c;
            sorted_o[1] = a;
            sorted_o[2] = b;
        end else if (le02) begin
            sorted_o[0] = b;
            sorted_o[1] = a;
            sorted_o[2] = c;
        end else if (le12) begin
            sorted_o[0] = b;
            sorted_o[1] = c;
            sorted_o[2] = a;
        end else begin
            sorted_o[0] = c;
            sorted_o[1] = b;
            sorted_o[2] = a;
        end
    end

endmodule

// File: rtl/float_triplet_collect_sort.sv
// Collects serial FP beats into triples, sorts each triple and offers it on a valid/ready
// output, counting delivered triples that carried a NaN operand.
module float_triplet_collect_sort
    import float_sort_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          up_valid,
    input  logic [FLEN-1:0]               up_data,
    output logic                          up_ready,
    output logic                          down_valid,
    output logic [0:TRIPLE_N-1][FLEN-1:0] down_data,
    output logic                          down_err,
    input  logic                          down_ready,
    output logic [CNT_W-1:0]              err_count
);

    triplet_state_t                  state_q;
    triplet_state_t                  state_d;
    logic [TRIPLE_N-1:0][FLEN-1:0]   slot_q;
    logic [TRIPLE_N-1:0][FLEN-1:0]   slot_d;
    logic [CNT_W-1:0]                errCnt_q;
    logic [CNT_W-1:0]                errCnt_d;
    logic                            accept;
    logic                            outHs;
    logic                            sortErr;

    sort_three_floats u_sort (
        .slots_i  (slot_q),
        .sorted_o (down_data),
        .err_o    (sortErr)
    );

    assign up_ready   = (state_q != FULL) | down_ready;
    assign down_valid = (state_q == FULL);
    assign down_err   = sortErr;
    assign err_count  = errCnt_q;
    assign accept     = up_valid & up_ready;
    assign outHs      = down_valid & down_ready;

    // Flush only discards partial triples; a completed triple in FULL is always delivered.
    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        errCnt_d = errCnt_q;
        if (outHs && sortErr && (errCnt_q != {CNT_W{1'b1}})) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
        case (state_q)
            FILL0: begin
                if (accept && !flush) begin
                    slot_d[0] = up_data;
                    state_d   = FILL1;
                end
            end
            FILL1: begin
                if (flush) begin
                    state_d = FILL0;
                end else if (accept) begin
                    slot_d[1] = up_data;
                    state_d   = FILL2;
                end
            end
            FILL2: begin
                if (flush) begin
                    state_d = FILL0;
                end else if (accept) begin
                    slot_d[2] = up_data;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (outHs) begin
                    if (accept) begin
                        slot_d[0] = up_data;
                        state_d   = FILL1;
                    end else begin
                        state_d = FILL0;
                    end
                end
            end
            default: state_d = FILL0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL0;
            errCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            errCnt_q <= errCnt_d;
        end
    end

    // Slot contents are don't-care after reset, so they carry no reset term.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: tb/tb_float_triplet_collect_sort.sv
// Self-checking bench: directed FP64 scenarios plus randomized traffic against a queue model.
module tb_float_triplet_collect_sort;

    localparam logic [63:0] P05 = 64'h3FE0_0000_0000_0000;
    localparam logic [63:0] P1  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] P2  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] P3  = 64'h4008_0000_0000_0000;
    localparam logic [63:0] P4  = 64'h4010_0000_0000_0000;
    localparam logic [63:0] P5  = 64'h4014_0000_0000_0000;
    localparam logic [63:0] P6  = 64'h4018_0000_0000_0000;
    localparam logic [63:0] P7  = 64'h401C_0000_0000_0000;
    localparam logic [63:0] P9  = 64'h4022_0000_0000_0000;
    localparam logic [63:0] M1  = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] QN  = 64'h7FF8_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             up_valid = 1'b0;
    logic [63:0]      up_data = '0;
    logic             down_ready = 1'b0;
    logic             up_ready;
    logic             down_valid;
    logic [0:2][63:0] down_data;
    logic             down_err;
    logic [7:0]       err_count;
    logic             up_ready2;
    logic             down_valid2;
    logic [0:2][63:0] down_data2;
    logic             down_err2;
    logic [1:0]       err_count2;

    int checks = 0;
    int errors = 0;

    float_triplet_collect_sort dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_err   (down_err),
        .down_ready (down_ready),
        .err_count  (err_count)
    );

    float_triplet_collect_sort #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready2),
        .down_valid (down_valid2),
        .down_data  (down_data2),
        .down_err   (down_err2),
        .down_ready (down_ready),
        .err_count  (err_count2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkTriple(input string name, input logic [63:0] e0, input logic [63:0] e1,
                               input logic [63:0] e2);
        checkOutput({name, "_valid"}, {63'd0, down_valid}, 64'd1);
        checkOutput({name, "_d0"}, down_data[0], e0);
        checkOutput({name, "_d1"}, down_data[1], e1);
        checkOutput({name, "_d2"}, down_data[2], e2);
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic v, input logic [63:0] d,
                                 input logic dr);
        rst        = r;
        flush      = f;
        up_valid   = v;
        up_data    = d;
        down_ready = dr;
        @(posedge clk);
        #1;
    endtask

    function automatic bit isNan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    endfunction

    function automatic logic [63:0] randVal();
        int  pick;
        real v;
        pick = int'($urandom_range(0, 99));
        if (pick < 5) return QN;
        v = real'(int'($urandom_range(0, 40)) - 20) * 0.25;
        return $realtobits(v);
    endfunction

    task automatic sortModel(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                             output logic [63:0] s0, output logic [63:0] s1, output logic [63:0] s2);
        real r [3];
        real t;
        r[0] = $bitstoreal(a);
        r[1] = $bitstoreal(b);
        r[2] = $bitstoreal(c);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2 - i; j++) begin
                if (r[j] > r[j+1]) begin
                    t      = r[j];
                    r[j]   = r[j+1];
                    r[j+1] = t;
                end
            end
        end
        s0 = $realtobits(r[0]);
        s1 = $realtobits(r[1]);
        s2 = $realtobits(r[2]);
    endtask

    // Reference model: a queue of pending beats and at most one completed triple.
    bit          modelOn = 1'b0;
    logic [63:0] part[$];
    bit          pend = 1'b0;
    logic [63:0] pendData [3];
    bit          pendErr = 1'b0;
    int          errTotal = 0;

    always @(negedge clk) begin
        bit          wasPend;
        bit          acc;
        bit          dropBeat;
        logic [63:0] s0, s1, s2;
        if (modelOn) begin
            checkOutput("down_valid", {63'd0, down_valid}, {63'd0, pend});
            checkOutput("up_ready", {63'd0, up_ready}, {63'd0, (!pend) || down_ready});
            checkOutput("err_count", {56'd0, err_count}, (errTotal > 255) ? 64'd255 : 64'(errTotal));
            checkOutput("err_count_w2", {62'd0, err_count2}, (errTotal > 3) ? 64'd3 : 64'(errTotal));
            if (pend) begin
                checkOutput("down_err", {63'd0, down_err}, {63'd0, pendErr});
                if (!pendErr) begin
                    for (int i = 0; i < 3; i++) checkOutput("down_data", down_data[i], pendData[i]);
                end
            end
        end
        if (rst) begin
            modelOn  = 1'b1;
            part.delete();
            pend     = 1'b0;
            errTotal = 0;
        end else if (modelOn) begin
            wasPend  = pend;
            acc      = up_valid && (!pend || down_ready);
            dropBeat = flush && !wasPend;
            if (pend && down_ready) begin
                if (pendErr) errTotal++;
                pend = 1'b0;
            end
            if (dropBeat) part.delete();
            if (acc && !dropBeat) begin
                part.push_back(up_data);
                if (part.size() == 3) begin
                    sortModel(part[0], part[1], part[2], s0, s1, s2);
                    pendData[0] = s0;
                    pendData[1] = s1;
                    pendData[2] = s2;
                    pendErr     = isNan(part[0]) || isNan(part[1]) || isNan(part[2]);
                    pend        = 1'b1;
                    part.delete();
                end
            end
        end
    end

    initial begin
        logic [63:0] stream [9];
        logic [63:0] expTrip [9];
        logic [63:0] nanTrip [3];

        // Reset then a single back-to-back triple.
        applyStimulus(1, 0, 0, '0, 1);
        applyStimulus(1, 0, 0, '0, 1);
        checkOutput("rst_down_valid", {63'd0, down_valid}, 64'd0);
        checkOutput("rst_up_ready", {63'd0, up_ready}, 64'd1);
        checkOutput("rst_err_count", {56'd0, err_count}, 64'd0);
        applyStimulus(0, 0, 1, P3, 1);
        applyStimulus(0, 0, 1, P1, 1);
        checkOutput("t1_not_yet", {63'd0, down_valid}, 64'd0);
        applyStimulus(0, 0, 1, P2, 1);
        checkTriple("t1", P1, P2, P3);
        checkOutput("t1_err", {63'd0, down_err}, 64'd0);
        checkOutput("t1_err_count", {56'd0, err_count}, 64'd0);
        applyStimulus(0, 0, 0, '0, 1);
        checkOutput("t1_drained", {63'd0, down_valid}, 64'd0);

        // Continuous stream of nine beats.
        stream  = '{P2, M1, P1, P3, P1, P2, P6, P5, P4};
        expTrip = '{M1, P1, P2, P1, P2, P3, P4, P5, P6};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(0, 0, 1, stream[i], 1);
            checkOutput("t2_up_ready", {63'd0, up_ready}, 64'd1);
            if (i % 3 == 2) checkTriple("t2", expTrip[i-2], expTrip[i-1], expTrip[i]);
        end
        applyStimulus(0, 0, 0, '0, 1);

        // Backpressure holds the triple and blocks the extra beat.
        applyStimulus(0, 0, 1, P1, 0);
        applyStimulus(0, 0, 1, P3, 0);
        applyStimulus(0, 0, 1, P2, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, P7, 0);
            checkOutput("t3_up_ready", {63'd0, up_ready}, 64'd0);
            checkTriple("t3_stall", P1, P2, P3);
        end
        applyStimulus(0, 0, 1, P7, 1);
        checkOutput("t3_after_hs", {63'd0, down_valid}, 64'd0);
        applyStimulus(0, 0, 1, P05, 1);
        applyStimulus(0, 0, 1, P9, 1);
        checkTriple("t3_next", P05, P7, P9);
        applyStimulus(0, 0, 0, '0, 1);

        // Flush discards a partial triple and the same-cycle beat.
        applyStimulus(0, 0, 1, P1, 1);
        applyStimulus(0, 0, 1, P2, 1);
        applyStimulus(0, 1, 1, P3, 1);
        applyStimulus(0, 0, 0, '0, 1);
        checkOutput("t4_flushed", {63'd0, down_valid}, 64'd0);
        applyStimulus(0, 0, 1, P3, 1);
        applyStimulus(0, 0, 1, P2, 1);
        checkOutput("t4_partial", {63'd0, down_valid}, 64'd0);
        applyStimulus(0, 0, 1, P1, 1);
        checkTriple("t4", P1, P2, P3);
        applyStimulus(0, 0, 0, '0, 1);

        // NaN triples flag down_err and the narrow counter saturates.
        applyStimulus(1, 0, 0, '0, 1);
        nanTrip = '{QN, P1, P2};
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < 3; j++) begin
                applyStimulus(0, 0, 1, nanTrip[(j + t) % 3], 1);
                if (t == 1 && j == 0) checkOutput("t5_err_count1", {56'd0, err_count}, 64'd1);
            end
            if (t == 0) checkOutput("t5_down_err", {63'd0, down_err}, 64'd1);
        end
        applyStimulus(0, 0, 0, '0, 1);
        checkOutput("t5_err_count4", {56'd0, err_count}, 64'd4);
        checkOutput("t5_err_sat", {62'd0, err_count2}, 64'd3);

        // Reset in FILL2 and in FULL.
        applyStimulus(0, 0, 1, P1, 1);
        applyStimulus(0, 0, 1, P2, 1);
        applyStimulus(1, 0, 0, '0, 1);
        checkOutput("t6a_valid", {63'd0, down_valid}, 64'd0);
        checkOutput("t6a_up_ready", {63'd0, up_ready}, 64'd1);
        checkOutput("t6a_err_count", {56'd0, err_count}, 64'd0);
        applyStimulus(0, 0, 1, QN, 1);
        applyStimulus(0, 0, 1, P1, 1);
        applyStimulus(0, 0, 1, P2, 1);
        applyStimulus(0, 0, 0, '0, 1);
        checkOutput("t6_err_count1", {56'd0, err_count}, 64'd1);
        applyStimulus(0, 0, 1, P5, 0);
        applyStimulus(0, 0, 1, P4, 0);
        applyStimulus(0, 0, 1, P6, 0);
        applyStimulus(0, 0, 0, '0, 0);
        checkTriple("t6_full", P4, P5, P6);
        applyStimulus(1, 0, 0, '0, 0);
        checkOutput("t6b_valid", {63'd0, down_valid}, 64'd0);
        checkOutput("t6b_up_ready", {63'd0, up_ready}, 64'd1);
        checkOutput("t6b_err_count", {56'd0, err_count}, 64'd0);
        applyStimulus(0, 0, 1, P3, 1);
        applyStimulus(0, 0, 1, P1, 1);
        applyStimulus(0, 0, 1, P2, 1);
        checkTriple("t6_after", P1, P2, P3);
        applyStimulus(0, 0, 0, '0, 1);

        // Randomized traffic, checked every cycle by the model process.
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 299) == 0),
                          ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 3) != 0),
                          randVal(),
                          ($urandom_range(0, 9) < 7));
        end
        applyStimulus(0, 0, 0, '0, 1);
        applyStimulus(0, 0, 0, '0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
